timer_core: RTL and testbench
=============================

# timer_core

Programmable free-running cycle counter with a terminal-count strobe. It counts enabled clock cycles up to a runtime-programmable limit, then wraps to zero and raises a one-cycle finish pulse. It is the base time-keeping block of the alarm main module, used to pace LED multiplexing, blink rates and timeouts. Each consumer instantiates its own copy, clocked from the system clock.

## Interface
- `WIDTH`, default 18: width of `maxCount` and `clkCont`.
- `clkSignal` input 1: system clock; all state changes on its rising edge.
- `RST` input 1: reset. One clock; reset is asynchronous and active-low.
- `EN` input 1: count enable, sampled on the rising edge.
- `maxCount` input WIDTH: period in enabled cycles; may change at any time.
- `clkCont` output WIDTH: current count, registered.
- `clkFinish` output 1: terminal-count strobe, registered, one cycle wide.

## Operation
- Reset (`RST`=0): `clkCont`=0 and `clkFinish`=0 immediately, independent of the clock. Both hold at 0 while `RST` is low.
- Each rising edge with `RST`=1 and `EN`=1:
  - If `clkCont` >= `maxCount`-1: `clkCont` <= 0 and `clkFinish` <= 1 (terminal count).
  - Otherwise: `clkCont` <= `clkCont`+1 and `clkFinish` <= 0.
- Each rising edge with `EN`=0: `clkCont` holds its value and `clkFinish` <= 0. A pause never produces or stretches a strobe.
- The period is `maxCount` enabled cycles. The count sequence is 0..`maxCount`-1.
- `maxCount`=0 behaves exactly like `maxCount`=1: `clkCont` stays 0 and `clkFinish`=1 on every enabled cycle. Compute `maxCount`-1 so that 0 does not underflow.
- `maxCount` lowered below the current count: the >= compare forces a wrap on the next enabled edge. The count never runs past the limit to 2^WIDTH.
- `maxCount` raised mid-period: the current period extends to the new limit. No strobe is lost or duplicated.
- Arithmetic is unsigned WIDTH-bit. `clkCont` never exceeds max(`maxCount`-1, 0), except for the one cycle after `maxCount` is lowered.

## Timing
- Latency from `RST` rising to the first increment: one rising edge.
- `clkFinish` is high for exactly one clock, in the cycle following the edge that wrapped `clkCont` to 0. It coincides with `clkCont`=0.
- For constant `maxCount`=N and continuous `EN`, `clkFinish` rises every N clocks. The first rise is N edges after reset release.
- Deasserting reset near a clock edge is the system's responsibility. Internally the block needs no synchronizer.
- Reset asserted mid-period clears the count at once. A strobe that is high is cut short immediately.

## Configuration
- `TIMER_ONESHOT_EN` not defined (default): free-running auto-reload as described above.
- `TIMER_ONESHOT_EN` defined:
  - After the first terminal count, `clkCont` stays 0 and `clkFinish` stays 0, regardless of `EN`.
  - Only a reset re-arms the timer.
  - An internal `done` flag, cleared by reset, implements this.

## Test plan
- Reset: hold `RST`=0 for 3 edges with `EN`=1 -> `clkCont`=0 and `clkFinish`=0 throughout. Release -> `clkCont` reads 1,2,3,4,0 on edges 1-5 with `maxCount`=5, and `clkFinish`=1 only after edge 5.
- Periodicity: `maxCount`=5, `EN`=1, 30 edges -> `clkFinish` pulses 6 times, each 1 cycle wide, 5 cycles apart.
- Runtime reprogramming: decrement `maxCount` 5->4->3->2->1 after every 4th strobe, with 1 wrapping back to 5. Spacing follows the new value from the next period on. With `maxCount`=1, `clkFinish` stays high every cycle.
- Enable gating: `maxCount`=5; drop `EN` for 3 cycles when `clkCont`=2 -> count holds at 2, no strobe. The strobe arrives 3 cycles late.
- Boundaries:
  - `maxCount`=0 -> same as 1.
  - `clkCont`=4 with `maxCount` changed 10->3 -> wrap to 0 plus a strobe on the next edge.
  - `maxCount`=2^18-1 -> `clkCont` reaches 262142 then wraps.
- Async reset mid-count: assert `RST` between edges at `clkCont`=3 -> outputs clear before the next edge. With `TIMER_ONESHOT_EN`, exactly one strobe per reset.

Source files
------------

// File: rtl/timer_core.sv
// Programmable free-running cycle counter with a one-cycle terminal-count strobe.
// Define TIMER_ONESHOT_EN to stop the timer after its first terminal count until reset.
module timer_core #(
    parameter int WIDTH = 18
) (
    input  logic             clkSignal,
    input  logic             RST,
    input  logic             EN,
    input  logic [WIDTH-1:0] maxCount,
    output logic [WIDTH-1:0] clkCont,
    output logic             clkFinish
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             finish_q, finish_d;
    logic [WIDTH-1:0] last_value;
    logic             at_terminal;

    // maxCount of 0 is treated as 1, so the terminal value never underflows.
    assign last_value  = (maxCount == '0) ? '0 : maxCount - WIDTH'(1);
    assign at_terminal = (count_q >= last_value);

`ifdef TIMER_ONESHOT_EN
    logic done_q, done_d;

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        count_d  = count_q;
        finish_d = 1'b0;
        done_d   = done_q;
        if (done_q) begin
            count_d = '0;
        end else if (EN) begin
            if (at_terminal) begin
                count_d  = '0;
                finish_d = 1'b1;
                done_d   = 1'b1;
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clkSignal or negedge RST) begin
        if (!RST) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end
`else
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        count_d  = count_q;
        finish_d = 1'b0;
        if (EN) begin
            if (at_terminal) begin
                count_d  = '0;
                finish_d = 1'b1;
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end
    end
`endif

    always_ff @(posedge clkSignal or negedge RST) begin
        if (!RST) begin
            count_q  <= '0;
            finish_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            count_q  <= count_d;
            finish_q <= finish_d;
        end
    end

    assign clkCont   = count_q;
    assign clkFinish = finish_q;

endmodule

// File: tb/tb_timer_core.sv
// Self-checking bench for timer_core: randomized and directed stimulus against a
// period-based reference model (honours TIMER_ONESHOT_EN when defined).
module tb_timer_core;

    logic        clkSignal = 1'b0;
    logic        RST = 1'b0;
    logic        EN = 1'b0;
    logic [17:0] maxCount = 18'd5;
    logic [17:0] clkCont;
    logic        clkFinish;

    logic [9:0]  small_max = 10'd1023;
    logic [9:0]  small_cont;
    logic        small_fin;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_cnt = 0;
    bit m_fin = 0;
    bit m_done = 0;

    timer_core u_dut (
        .clkSignal (clkSignal),
        .RST       (RST),
        .EN        (EN),
        .maxCount  (maxCount),
        .clkCont   (clkCont),
        .clkFinish (clkFinish)
    );

    timer_core #(.WIDTH(10)) u_small (
        .clkSignal (clkSignal),
        .RST       (RST),
        .EN        (EN),
        .maxCount  (small_max),
        .clkCont   (small_cont),
        .clkFinish (small_fin)
    );

    always #5 clkSignal = ~clkSignal;

    // One enabled cycle advances position within a period of max(maxCount,1) cycles.
    task automatic model_edge();
        int period;
        if (!RST) begin
            m_cnt = 0; m_fin = 0; m_done = 0;
        end else if (m_done) begin
            m_cnt = 0; m_fin = 0;
        end else if (!EN) begin
            m_fin = 0;
        end else begin
            period = (maxCount == 0) ? 1 : int'(maxCount);
            if (m_cnt + 1 >= period) begin
                m_cnt = 0;
                m_fin = 1;
`ifdef TIMER_ONESHOT_EN
                m_done = 1;
`endif
            end else begin
                m_cnt = m_cnt + 1;
                m_fin = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clkSignal);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        #1;
        m_cnt = 0; m_fin = 0; m_done = 0;
        step();
        RST = 1'b1;
    endtask

    task automatic test_reset();
        int exp_cnt [5] = '{1, 2, 3, 4, 0};
        RST = 1'b0; EN = 1'b1; maxCount = 18'd5;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (clkCont !== 18'd0 || clkFinish !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold edge%0d cnt=%0d fin=%0b want cnt=0 fin=0", i, clkCont, clkFinish);
            end
        end
        RST = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (clkCont !== 18'(exp_cnt[i]) || clkFinish !== (i == 4)) begin
                errors++;
                $display("FAIL reset_release edge%0d cnt=%0d fin=%0b want cnt=%0d fin=%0b",
                         i + 1, clkCont, clkFinish, exp_cnt[i], (i == 4));
            end
        end
    endtask

    task automatic test_periodicity();
        int pulses = 0;
        int last = -1;
        EN = 1'b1; maxCount = 18'd5;
        do_reset();
        for (int i = 1; i <= 30; i++) begin
            step();
            checks++;
            if (clkCont !== 18'(m_cnt) || clkFinish !== m_fin) begin
                errors++;
                $display("FAIL period edge%0d cnt=%0d fin=%0b want cnt=%0d fin=%0b", i, clkCont, clkFinish, m_cnt, m_fin);
            end
            if (clkFinish === 1'b1) begin
`ifndef TIMER_ONESHOT_EN
                if (last >= 0) begin
                    checks++;
                    if (i - last != 5) begin
                        errors++;
                        $display("FAIL period_gap edge%0d gap=%0d want 5", i, i - last);
                    end
                end
`endif
                last = i;
                pulses++;
            end
        end
        checks++;
`ifdef TIMER_ONESHOT_EN
        if (pulses != 1) begin
            errors++;
            $display("FAIL period_pulses got=%0d want 1", pulses);
        end
`else
        if (pulses != 6) begin
            errors++;
            $display("FAIL period_pulses got=%0d want 6", pulses);
        end
`endif
    endtask

    task automatic test_reprogram();
        int strobes = 0;
        EN = 1'b1; maxCount = 18'd5;
        do_reset();
        for (int i = 0; i < 90; i++) begin
            step();
            checks++;
            if (clkCont !== 18'(m_cnt) || clkFinish !== m_fin) begin
                errors++;
                $display("FAIL reprogram step%0d max=%0d cnt=%0d fin=%0b want cnt=%0d fin=%0b",
                         i, maxCount, clkCont, clkFinish, m_cnt, m_fin);
            end
            if (m_fin) strobes++;
            if (strobes == 4) begin
                strobes = 0;
                maxCount = (maxCount == 18'd1) ? 18'd5 : maxCount - 18'd1;
            end
        end
    endtask

    task automatic test_enable_gating();
        EN = 1'b1; maxCount = 18'd5;
        do_reset();
        step(); step();
        EN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (clkCont !== 18'd2 || clkFinish !== 1'b0 || m_cnt != 2) begin
                errors++;
                $display("FAIL enable_hold cyc%0d cnt=%0d fin=%0b want cnt=2 fin=0", i, clkCont, clkFinish);
            end
        end
        EN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (clkCont !== 18'(m_cnt) || clkFinish !== m_fin || clkFinish !== (i == 2)) begin
                errors++;
                $display("FAIL enable_resume cyc%0d cnt=%0d fin=%0b want cnt=%0d fin=%0b", i, clkCont, clkFinish, m_cnt, m_fin);
            end
        end
    endtask

    task automatic test_boundaries();
        // maxCount = 0 behaves as 1
        EN = 1'b1; maxCount = 18'd0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (clkCont !== 18'(m_cnt) || clkFinish !== m_fin) begin
                errors++;
                $display("FAIL max_zero cyc%0d cnt=%0d fin=%0b want cnt=%0d fin=%0b", i, clkCont, clkFinish, m_cnt, m_fin);
            end
        end
        // Limit lowered below current count forces a wrap on the next edge
        maxCount = 18'd10;
        do_reset();
        for (int i = 0; i < 4; i++) step();
        maxCount = 18'd3;
        step();
        checks++;
        if (clkCont !== 18'd0 || clkFinish !== 1'b1) begin
            errors++;
            $display("FAIL lower_limit cnt=%0d fin=%0b want cnt=0 fin=1", clkCont, clkFinish);
        end
        // All-ones limit on a narrow instance: counts to 2^W-2 then wraps
        small_max = 10'd1023;
        do_reset();
        for (int i = 1; i <= 1023; i++) begin
            step();
            if (i == 1022 || i == 1023) begin
                checks++;
                if (small_cont !== ((i == 1022) ? 10'd1022 : 10'd0) || small_fin !== (i == 1023)) begin
                    errors++;
                    $display("FAIL all_ones edge%0d cnt=%0d fin=%0b want cnt=%0d fin=%0b",
                             i, small_cont, small_fin, (i == 1022) ? 1022 : 0, (i == 1023));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        EN = 1'b1; maxCount = 18'd5;
        do_reset();
        step(); step(); step();
        #2 RST = 1'b0;
        #1;
        m_cnt = 0; m_fin = 0; m_done = 0;
        checks++;
        if (clkCont !== 18'd0 || clkFinish !== 1'b0) begin
            errors++;
            $display("FAIL async_mid cnt=%0d fin=%0b want cnt=0 fin=0", clkCont, clkFinish);
        end
        step();
        RST = 1'b1;
        maxCount = 18'd1;
        step();
        #2 RST = 1'b0;
        #1;
        m_cnt = 0; m_fin = 0; m_done = 0;
        checks++;
        if (clkFinish !== 1'b0) begin
            errors++;
            $display("FAIL async_strobe fin=%0b want 0", clkFinish);
        end
        step();
        RST = 1'b1;
    endtask

    task automatic test_random();
        EN = 1'b1; maxCount = 18'd7;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            EN = ($urandom_range(3, 0) != 0);
            if ($urandom_range(15, 0) == 0) maxCount = 18'($urandom_range(12, 0));
            if ($urandom_range(199, 0) == 0) do_reset();
            step();
            checks++;
            if (clkCont !== 18'(m_cnt) || clkFinish !== m_fin) begin
                errors++;
                $display("FAIL random step%0d en=%0b max=%0d cnt=%0d fin=%0b want cnt=%0d fin=%0b",
                         i, EN, maxCount, clkCont, clkFinish, m_cnt, m_fin);
            end
        end
    endtask

    initial begin
        test_reset();
        test_periodicity();
        test_reprogram();
        test_enable_gating();
        test_boundaries();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
